// File: rtl/adrv9001_dgpio_pkg.sv
// Shared types and limits for the ADRV9001 DGPIO controller.
package adrv9001_dgpio_pkg;

  localparam int MAX_PINS        = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  typedef enum logic {
    PULSE_IDLE   = 1'b0,
    PULSE_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/adrv9001_dgpio_pulse.sv
// Single-pin timed pulse generator: drives the inverted static level for
// exactly len_i cycles after an accepted trigger, then returns to it.
module adrv9001_dgpio_pulse
  import adrv9001_dgpio_pkg::*;
#(
  parameter int PULSE_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  // trig_i is a single-cycle request with no back-pressure; it is accepted
  // only in IDLE with en_i high and a non-zero length, otherwise dropped.
  input  logic               trig_i,
  input  logic               en_i,
  input  logic [PULSE_W-1:0] len_i,
  input  logic               level_i,
  output logic               pin_o,
  output pulse_state_e       state_o
);

  pulse_state_e       state_q, state_d;
  logic [PULSE_W-1:0] cnt_q, cnt_d;
  logic               pin_q, pin_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PULSE_IDLE: begin
        if (trig_i && en_i && (len_i != '0)) begin
          state_d = PULSE_ACTIVE;
          cnt_d   = len_i - PULSE_W'(1);
        end
      end
      PULSE_ACTIVE: begin
        // The entry cycle already counts, so cnt == 0 marks the last one.
        if (!en_i || (cnt_q == '0)) begin
          state_d = PULSE_IDLE;
        end else begin
          cnt_d = cnt_q - PULSE_W'(1);
        end
      end
      default: state_d = PULSE_IDLE;
    endcase
    pin_d = (state_d == PULSE_ACTIVE) ? ~level_i : level_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PULSE_IDLE;
      cnt_q   <= '0;
      pin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
    end
  end

  assign pin_o   = pin_q;
  assign state_o = state_q;

endmodule

// File: rtl/adrv9001_dgpio_ctrl.sv
// DGPIO bank controller: registered direction/output drive, synchronised
// inputs with sticky edge status and interrupt, and per-pin timed pulses.
module adrv9001_dgpio_ctrl
  import adrv9001_dgpio_pkg::*;
#(
  parameter int NUM_PINS    = 12,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PINS-1:0] dgpio_i,
  output logic [NUM_PINS-1:0] dgpio_o,
  output logic [NUM_PINS-1:0] dgpio_t,
  input  logic [NUM_PINS-1:0] cfg_dir,
  input  logic [NUM_PINS-1:0] cfg_out,
  input  logic [NUM_PINS-1:0] cfg_pulse_en,
  input  logic [PULSE_W-1:0]  pulse_len,
  input  logic [NUM_PINS-1:0] pulse_trig,
  output logic [NUM_PINS-1:0] pulse_busy,
  input  logic [NUM_PINS-1:0] cfg_rise_en,
  input  logic [NUM_PINS-1:0] cfg_fall_en,
  output logic [NUM_PINS-1:0] pin_level,
  output logic [NUM_PINS-1:0] status,
  input  logic [NUM_PINS-1:0] status_clr,
  output logic                irq
);

  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] level;
  logic [NUM_PINS-1:0] prev_q;
  logic [NUM_PINS-1:0] rise, fall, edge_set;
  logic [NUM_PINS-1:0] status_q, status_d;
  logic [NUM_PINS-1:0] dgpio_t_q;
  logic                irq_q;
  logic [NUM_PINS-1:0] pulse_en;
  pulse_state_e        pulse_state [NUM_PINS];

  // Input synchroniser chain; the last stage is the usable pin level.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= dgpio_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

  // Edges are only meaningful on pins we are not driving ourselves.
  always_comb begin
    rise     = level & ~prev_q;
    fall     = ~level & prev_q;
    edge_set = ((rise & cfg_rise_en) | (fall & cfg_fall_en)) & ~cfg_dir;
    status_d = (status_q & ~status_clr) | edge_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
      dgpio_t_q <= '1;
    end else begin
      prev_q    <= level;
      status_q  <= status_d;
      irq_q     <= |status_q;
      dgpio_t_q <= ~cfg_dir;
    end
  end

  assign pulse_en = cfg_pulse_en & cfg_dir;

  for (genvar n = 0; n < NUM_PINS; n++) begin : g_pulse
    adrv9001_dgpio_pulse #(
      .PULSE_W (PULSE_W)
    ) u_pulse (
      .clk_i   (clk),
      .rst_i   (rst),
      .trig_i  (pulse_trig[n]),
      .en_i    (pulse_en[n]),
      .len_i   (pulse_len),
      .level_i (cfg_out[n]),
      .pin_o   (dgpio_o[n]),
      .state_o (pulse_state[n])
    );
    assign pulse_busy[n] = (pulse_state[n] == PULSE_ACTIVE);
  end

  assign dgpio_t   = dgpio_t_q;
  assign pin_level = level;
  assign status    = status_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_adrv9001_dgpio_ctrl.sv
// Scoreboard bench for adrv9001_dgpio_ctrl against a cycle-level reference model.
module tb_adrv9001_dgpio_ctrl;

  localparam int N  = 12;
  localparam int S  = 2;
  localparam int PW = 16;
  localparam int W  = 5 * N + 1;

  // clock / reset / stimulus signals
  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  dgpio_i, cfg_dir, cfg_out, cfg_pulse_en, pulse_trig;
  logic [N-1:0]  cfg_rise_en, cfg_fall_en, status_clr;
  logic [PW-1:0] pulse_len;
  logic [N-1:0]  dgpio_o, dgpio_t, pulse_busy, pin_level, status;
  logic          irq;

  always #5 clk = ~clk;

  adrv9001_dgpio_ctrl #(
    .NUM_PINS    (N),
    .SYNC_STAGES (S),
    .PULSE_W     (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dgpio_i      (dgpio_i),
    .dgpio_o      (dgpio_o),
    .dgpio_t      (dgpio_t),
    .cfg_dir      (cfg_dir),
    .cfg_out      (cfg_out),
    .cfg_pulse_en (cfg_pulse_en),
    .pulse_len    (pulse_len),
    .pulse_trig   (pulse_trig),
    .pulse_busy   (pulse_busy),
    .cfg_rise_en  (cfg_rise_en),
    .cfg_fall_en  (cfg_fall_en),
    .pin_level    (pin_level),
    .status       (status),
    .status_clr   (status_clr),
    .irq          (irq)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // reference model: observable outputs after each clock edge
  logic [N-1:0] m_o, m_t, m_lvl, m_lvl_prev, m_st, m_busy;
  logic         m_irq;
  logic [N-1:0] m_pipe[$];
  int           m_rem[N];

  function automatic void model_step();
    logic [N-1:0] set;
    if (rst) begin
      m_o = '0; m_t = '1; m_lvl = '0; m_lvl_prev = '0;
      m_st = '0; m_busy = '0; m_irq = 1'b0;
      m_pipe.delete();
      for (int i = 0; i < S - 1; i++) m_pipe.push_back('0);
      for (int n = 0; n < N; n++) m_rem[n] = 0;
    end else begin
      set = '0;
      for (int n = 0; n < N; n++) begin
        if (!cfg_dir[n] && ((cfg_rise_en[n] && m_lvl[n] && !m_lvl_prev[n]) ||
                            (cfg_fall_en[n] && !m_lvl[n] && m_lvl_prev[n])))
          set[n] = 1'b1;
      end
      m_irq = (m_st != '0);
      m_st = (m_st & ~status_clr) | set;
      m_lvl_prev = m_lvl;
      m_pipe.push_back(dgpio_i);
      m_lvl = m_pipe.pop_front();
      m_t = ~cfg_dir;
      for (int n = 0; n < N; n++) begin
        if (m_rem[n] > 0) begin
          m_rem[n] = (cfg_dir[n] && cfg_pulse_en[n]) ? m_rem[n] - 1 : 0;
        end else if (pulse_trig[n] && cfg_dir[n] && cfg_pulse_en[n] && pulse_len != 0) begin
          m_rem[n] = int'(pulse_len);
        end
        m_busy[n] = (m_rem[n] > 0);
        m_o[n] = m_busy[n] ? ~cfg_out[n] : cfg_out[n];
      end
    end
  endfunction

  // driver: inputs are already set; predict, queue, advance one cycle
  task automatic tick();
    model_step();
    exp_q.push_back({m_o, m_t, m_lvl, m_st, m_busy, m_irq});
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic clear_inputs();
    dgpio_i = '0; cfg_dir = '0; cfg_out = '0; cfg_pulse_en = '0;
    pulse_trig = '0; cfg_rise_en = '0; cfg_fall_en = '0;
    status_clr = '0; pulse_len = '0;
  endtask

  // monitor: compare each queued expectation on the falling edge
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dgpio_o",    dgpio_o,    e[W-1 -: N]);
        chk("dgpio_t",    dgpio_t,    e[W-1-N -: N]);
        chk("pin_level",  pin_level,  e[W-1-2*N -: N]);
        chk("status",     status,     e[W-1-3*N -: N]);
        chk("pulse_busy", pulse_busy, e[N:1]);
        chk("irq",        N'(irq),    N'(e[0]));
      end
    end
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      dgpio_i = N'($urandom); cfg_dir = N'($urandom); cfg_out = N'($urandom);
      cfg_pulse_en = N'($urandom); pulse_trig = N'($urandom);
      cfg_rise_en = N'($urandom); cfg_fall_en = N'($urandom);
      pulse_len = PW'($urandom_range(1, 5));
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    tick();

    // direction and static output
    cfg_dir = 12'h00F; cfg_out = 12'h005;
    ticks(3);

    // rising edge on pin 3, then clear
    cfg_dir = '0; cfg_out = '0; cfg_rise_en[3] = 1'b1;
    dgpio_i[3] = 1'b1;
    ticks(10);
    status_clr[3] = 1'b1;
    tick();
    status_clr[3] = 1'b0;
    ticks(4);

    // set/clear collision on pin 5, then same edge on an output pin
    cfg_rise_en[5] = 1'b1;
    dgpio_i[5] = 1'b1; status_clr[5] = 1'b1;
    ticks(3);
    status_clr[5] = 1'b0;
    ticks(3);
    status_clr[5] = 1'b1; dgpio_i[5] = 1'b0;
    ticks(4);
    status_clr[5] = 1'b0; cfg_dir[5] = 1'b1;
    ticks(2);
    dgpio_i[5] = 1'b1;
    ticks(6);
    status_clr = '1;
    tick();
    clear_inputs();
    ticks(3);

    // pulse on pin 0 with a retrigger, then zero length
    cfg_dir[0] = 1'b1; cfg_pulse_en[0] = 1'b1; pulse_len = 4;
    pulse_trig[0] = 1'b1;
    tick();
    pulse_trig[0] = 1'b0;
    tick();
    pulse_trig[0] = 1'b1;
    tick();
    pulse_trig[0] = 1'b0;
    ticks(6);
    pulse_len = 0; pulse_trig[0] = 1'b1;
    tick();
    pulse_trig[0] = 1'b0;
    ticks(4);

    // abort a 10-cycle pulse by clearing direction
    pulse_len = 10; pulse_trig[0] = 1'b1;
    tick();
    pulse_trig[0] = 1'b0;
    tick();
    cfg_dir[0] = 1'b0;
    ticks(4);

    // randomized traffic
    for (int blk = 0; blk < 40; blk++) begin
      cfg_dir = N'($urandom); cfg_out = N'($urandom);
      cfg_pulse_en = N'($urandom); cfg_rise_en = N'($urandom);
      cfg_fall_en = N'($urandom);
      for (int c = 0; c < 16; c++) begin
        rst = ($urandom_range(0, 63) == 0);
        dgpio_i = dgpio_i ^ (N'($urandom) & N'($urandom));
        pulse_trig = N'($urandom) & N'($urandom) & N'($urandom);
        status_clr = N'($urandom) & N'($urandom) & N'($urandom);
        if ($urandom_range(0, 3) == 0) pulse_len = PW'($urandom_range(0, 6));
        tick();
      end
    end
    rst = 1'b0;
    clear_inputs();
    ticks(4);

    @(negedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/adrv9001_dgpio_ctrl.md
Name: adrv9001_dgpio_ctrl

Overview:
- Parametrised DGPIO controller for the ADRV9001 digital GPIO bank; sits between the system block and the per-pin IOBUF array in the top level.
- Generalises the fixed 12-pin static tristate path to NUM_PINS pins.
- Adds input synchronisation, per-pin rise/fall edge capture with sticky status and an interrupt, and a per-pin timed output-pulse mode.

Parameters:
- NUM_PINS, 12, number of DGPIO pins handled (1..32).
- SYNC_STAGES, 2, flip-flop stages on each input (2..4).
- PULSE_W, 16, width of the pulse-length counter.

Ports:
- clk  in  1  block clock.
- rst  in  1  synchronous active-high reset.
- dgpio_i  in  NUM_PINS  raw pin levels from IOBUF O.
- dgpio_o  out  NUM_PINS  pin drive values to IOBUF I.
- dgpio_t  out  NUM_PINS  tristate to IOBUF T; 1 = input/high-Z.
- cfg_dir  in  NUM_PINS  1 = pin is an output.
- cfg_out  in  NUM_PINS  static output level.
- cfg_pulse_en  in  NUM_PINS  enables pulse mode per pin.
- pulse_len  in  PULSE_W  pulse length in clk cycles; shared by all pins.
- pulse_trig  in  NUM_PINS  single-cycle pulse start request per pin.
- pulse_busy  out  NUM_PINS  pin is currently pulsing.
- cfg_rise_en  in  NUM_PINS  capture rising edges.
- cfg_fall_en  in  NUM_PINS  capture falling edges.
- pin_level  out  NUM_PINS  synchronised input levels.
- status  out  NUM_PINS  sticky edge-captured flags.
- status_clr  in  NUM_PINS  write-1-to-clear for status.
- irq  out  1  OR of status, registered.

Behaviour:
- Clocking and reset:
  - One clock domain (clk); rst is synchronous and active-high.
  - Reset values: dgpio_t all 1, dgpio_o 0, pin_level 0, status 0, irq 0, pulse_busy 0.
  - All synchroniser and edge-history registers reset to 0.
- Direction:
  - dgpio_t = ~cfg_dir, registered (1-cycle latency).
- Static output:
  - When a pin is not pulsing, dgpio_o = cfg_out, registered (1-cycle latency).
- Input path:
  - dgpio_i passes through SYNC_STAGES flip-flops to give pin_level.
  - A pin change is visible on pin_level SYNC_STAGES cycles after the dgpio_i edge.
- Edge capture:
  - One history register per pin; rise = level & ~prev, fall = ~level & prev.
  - A qualified edge (rise & cfg_rise_en, or fall & cfg_fall_en) on a pin with cfg_dir = 0 sets status on the next edge.
  - Total latency dgpio_i -> status is SYNC_STAGES+1 cycles.
  - Edges on output-direction pins are never captured.
- Status clear:
  - status_clr[n] = 1 clears status[n].
  - A set and a clear on the same cycle: set wins, status stays 1.
- Interrupt:
  - irq is registered |status (one cycle after status changes).
  - irq deasserts one cycle after the last status bit clears.
- Pulse FSM (per pin), states IDLE and ACTIVE:
  - IDLE -> ACTIVE when pulse_trig & cfg_pulse_en & cfg_dir & (pulse_len != 0).
    - On entry: counter loads pulse_len-1, dgpio_o = ~cfg_out, pulse_busy = 1.
    - pulse_len is sampled at trigger; later changes do not affect a running pulse.
  - ACTIVE: counter decrements each cycle; ACTIVE -> IDLE when the counter is 0 and decrementing.
    - The inverted level lasts exactly pulse_len cycles.
    - dgpio_o returns to cfg_out the following cycle.
  - pulse_trig while ACTIVE is ignored (no retrigger, no extension).
  - cfg_dir or cfg_pulse_en dropping to 0 while ACTIVE aborts to IDLE on the next edge.
  - pulse_trig with pulse_len = 0 is ignored.
- Reset asserted mid-pulse forces IDLE and the reset values on the next edge.

Decomposition:
- Shared package adrv9001_dgpio_pkg:
  - Pulse-state enum (IDLE, ACTIVE).
  - MAX_PINS = 32 and the SYNC_STAGES min/max limits.
- One sub-module, adrv9001_dgpio_pulse: a single-pin pulse FSM plus counter, instantiated NUM_PINS times in a generate loop.
- The synchroniser and edge logic stay inline as vectors.

Test Plan:
- Reset: assert rst for 3 cycles with random inputs -> dgpio_t = all 1, dgpio_o = 0, status = 0, irq = 0.
- Direction: cfg_dir = 0x00F, cfg_out = 0x005 -> one cycle later dgpio_t = 0xFF0, dgpio_o = 0x005.
- Rising edge: cfg_rise_en[3] = 1, dgpio_i[3] 0->1 at cycle 0 -> status[3] = 1 at cycle 3, irq = 1 at cycle 4. With status_clr[3] pulsed at cycle 10 -> status = 0 at cycle 11, irq = 0 at cycle 12.
- Set/clear collision: a rising edge on pin 5 coincides with status_clr[5] = 1 -> status[5] stays 1. Repeat with cfg_dir[5] = 1 -> status[5] never sets.
- Pulse: pin 0 with cfg_dir = 1, cfg_out = 0, pulse_en = 1, pulse_len = 4, trig at cycle 0 -> dgpio_o[0] = 1 for exactly 4 cycles. A retrigger at cycle 2 is ignored; pulse_busy tracks the pulse. With pulse_len = 0 -> no pulse.
- Abort: cfg_dir[0] cleared 2 cycles into a 10-cycle pulse -> pulse_busy = 0 and dgpio_t[0] = 1 on the next edge.
